// File: rtl/vc_read_arbiter_pkg.sv
// Shared definitions for the VC read arbiter: control-FSM state encodings
// and a small one-hot decode helper.
package vc_read_arbiter_pkg;

  // One-hot control-FSM states driven on the arbiter's state input
  localparam logic [3:0] ST_RESET  = 4'b0001;
  localparam logic [3:0] ST_INIT   = 4'b0010;
  localparam logic [3:0] ST_IDLE   = 4'b0100;
  localparam logic [3:0] ST_ACTIVE = 4'b1000;

  // VC index reached first after reset so that VC0 wins the first grant
  localparam logic [1:0] LAST_GRANT_RESET = 2'd3;

  // Decode a one-hot (or zero) 4-bit vector into its bit index
  function automatic logic [1:0] onehot_to_idx(input logic [3:0] oh);
    logic [1:0] idx;
    idx = '0;
    for (int i = 0; i < 4; i++) begin
      if (oh[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/vc_read_arbiter_rr_select.sv
// Round-robin priority select over four requesters. The search starts at
// last+1 and wraps 3 -> 0, so the most recent winner has lowest priority.
module rr_select (
  input  logic [3:0] req,
  input  logic [1:0] last,
  output logic [3:0] gnt,
  output logic       valid
);

  logic [1:0] idx;
  logic       found;

  // Walk the four positions in rotated order and grant the first requester
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      idx = last + 2'(k);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

  assign valid = |req;

endmodule

// File: rtl/vc_read_arbiter.sv
// Reads words from four virtual-channel source FIFOs in round-robin order and
// pushes them into one downstream FIFO. Two-stage pipeline: pop in cycle N,
// push of that word in cycle N+1, so back-to-back pushes are possible when at
// least two VCs are requesting.
module vc_read_arbiter
  import vc_read_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W = 12,
  parameter int unsigned NUM_VC = 4
) (
  input  logic                     clk,
  input  logic                     reset_L,
  input  logic [3:0]               state,
  input  logic [3:0]               src_empty,
  input  logic [NUM_VC*DATA_W-1:0] src_data,
  input  logic                     dst_almost_full,
  output logic [3:0]               pop,
  output logic                     push,
  output logic [DATA_W-1:0]        data_out,
  output logic [1:0]               vc_id,
  output logic [7:0]               xfer_count
);

  logic [3:0]        req;
  logic [3:0]        gnt;
  logic              gnt_valid;
  logic [1:0]        pop_idx;

  logic [3:0]        pop_q, pop_d;
  logic [1:0]        last_q, last_d;
  // push_q doubles as the valid bit of the second pipeline stage
  logic              push_q, push_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [1:0]        vc_q, vc_d;
  logic [7:0]        cnt_q, cnt_d;

  // A VC popped last cycle still shows a stale non-empty flag, so it sits out
  // one cycle to avoid over-reading its FIFO.
  assign req     = ~src_empty & ~pop_q;
  assign pop_idx = onehot_to_idx(pop_q);

  rr_select u_rr_select (
    .req   (req),
    .last  (last_q),
    .gnt   (gnt),
    .valid (gnt_valid)
  );

  // Next-state: grant/pop stage, push stage, and transfer counter
  always_comb begin
    pop_d  = '0;
    last_d = last_q;
    push_d = 1'b0;
    data_d = data_q;
    vc_d   = vc_q;
    cnt_d  = cnt_q;

    if (push_q && (cnt_q != 8'hFF)) cnt_d = cnt_q + 8'd1;

    if (state == ST_RESET) begin
      // Synchronous clear; any word in flight is dropped
      last_d = LAST_GRANT_RESET;
      data_d = '0;
      vc_d   = '0;
      cnt_d  = '0;
    end else begin
      // A word popped last cycle is always pushed, whatever the state is now
      if (|pop_q) begin
        push_d = 1'b1;
        data_d = src_data[32'(pop_idx)*DATA_W +: DATA_W];
        vc_d   = pop_idx;
      end
      if ((state == ST_ACTIVE) && !dst_almost_full && gnt_valid) begin
        pop_d  = gnt;
        last_d = onehot_to_idx(gnt);
      end
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      pop_q  <= '0;
      last_q <= LAST_GRANT_RESET;
      push_q <= 1'b0;
      data_q <= '0;
      vc_q   <= '0;
      cnt_q  <= '0;
    end else begin
      pop_q  <= pop_d;
      last_q <= last_d;
      push_q <= push_d;
      data_q <= data_d;
      vc_q   <= vc_d;
      cnt_q  <= cnt_d;
    end
  end

  assign pop        = pop_q;
  assign push       = push_q;
  assign data_out   = data_q;
  assign vc_id      = vc_q;
  assign xfer_count = cnt_q;

endmodule
